// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t      : sequencer states (ASSERT, RELEASE, RUN)
//   CAUSE_*      : codes reported on rst_cause
//   cnt_width()  : width of the sequencer counters
//   pick_cause() : cause code when several triggers coincide
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    // One spare bit above what the largest terminal count needs, so a
    // saturating counter can never be mistaken for a wrapped one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    // Lock loss outranks the button, which outranks the software request.
    function automatic logic [1:0] pick_cause(input logic lock_lost,
                                              input logic btn_pressed);
        if (lock_lost)
            return CAUSE_LOCK;
        else if (btn_pressed)
            return CAUSE_BTN;
        else
            return CAUSE_SW;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a debounce counter.
// The debounced level only follows the synchronised input after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
//   clock    in   block clock
//   resetn   in   asynchronous active-low reset
//   din      in   raw asynchronous input (active-low button)
//   level    out  debounced level, resets to the released level (1)
module rst_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
            cnt    <= '0;
            level  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], din};
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= sync_q[1];
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset generator/sequencer. Debounces the push-button, synchronises the
// clock-lock flag, holds all resets for a minimum time once conditions are
// clean and then releases rst_n_out bit by bit, lowest bit first. Any trigger
// afterwards drops every output at once and records the cause.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ASSERT  | all resets low; hold counter runs while no trigger present
//   RELEASE | step counter runs; bit k released at step k*STEP_CYCLES
//   RUN     | all resets high, busy low; any trigger returns to ASSERT
//
// Ports:
//   clock       in   block clock
//   resetn      in   asynchronous active-low reset
//   button_n    in   raw push-button, active-low, asynchronous
//   locked      in   clock-source lock, asynchronous
//   sw_rst_req  in   one-cycle synchronous software reset request
//   rst_n_out   out  sequenced active-low resets, bit 0 released first
//   busy        out  high whenever the sequencer is not in RUN
//   rst_cause   out  cause of the last reset (POR/button/software/lock)
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_OUT           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STEP_CYCLES     = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             button_n,
    input  logic             locked,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             busy,
    output logic [1:0]       rst_cause
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES,
                                     (N_OUT - 1) * STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       lock_sync;
    logic             btn_level;
    logic             btn_pressed;
    logic             lock_lost;
    logic             trigger;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0] step_cnt, step_nxt;
    logic [N_OUT-1:0] out_nxt;
    logic             busy_nxt;
    logic [1:0]       cause_nxt;

    rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clock  (clock),
        .resetn (resetn),
        .din    (button_n),
        .level  (btn_level)
    );

    // Lock synchroniser resets to "unlocked" so the hold time only starts
    // once a real lock indication has crossed into this domain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            lock_sync <= 2'b00;
        else
            lock_sync <= {lock_sync[0], locked};
    end

    assign btn_pressed = ~btn_level;
    assign lock_lost   = ~lock_sync[1];
    assign trigger     = btn_pressed | lock_lost | sw_rst_req;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ASSERT;
            hold_cnt  <= '0;
            step_cnt  <= '0;
            rst_n_out <= '0;
            busy      <= 1'b1;
            rst_cause <= CAUSE_POR;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            step_cnt  <= step_nxt;
            rst_n_out <= out_nxt;
            busy      <= busy_nxt;
            rst_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        step_nxt  = step_cnt;
        out_nxt   = rst_n_out;
        cause_nxt = rst_cause;

        unique case (state)
            ASSERT: begin
                out_nxt  = '0;
                step_nxt = '0;
                if (trigger) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RELEASE;
                    hold_nxt  = '0;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end

            RELEASE: begin
                if (trigger) begin
                    state_nxt = ASSERT;
                    out_nxt   = '0;
                    hold_nxt  = '0;
                    step_nxt  = '0;
                    cause_nxt = pick_cause(lock_lost, btn_pressed);
                end else begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (step_cnt == CNT_W'(k * STEP_CYCLES))
                            out_nxt[k] = 1'b1;
                    end
                    // Leave one cycle after the last bit is released so busy
                    // trails the final output edge.
                    if (rst_n_out[N_OUT-1])
                        state_nxt = RUN;
                    if (step_cnt != '1)
                        step_nxt = step_cnt + 1'b1;
                end
            end

            RUN: begin
                out_nxt = '1;
                if (trigger) begin
                    state_nxt = ASSERT;
                    out_nxt   = '0;
                    hold_nxt  = '0;
                    step_nxt  = '0;
                    cause_nxt = pick_cause(lock_lost, btn_pressed);
                end
            end

            default: begin
                state_nxt = ASSERT;
                out_nxt   = '0;
                hold_nxt  = '0;
                step_nxt  = '0;
            end
        endcase

        busy_nxt = (state_nxt != RUN);
    end

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       button_n;
    logic       locked;
    logic       sw_rst_req;
    logic [3:0] rst_n_out;
    logic       busy;
    logic [1:0] rst_cause;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rst_sequencer #(
        .N_OUT           (4),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (16),
        .STEP_CYCLES     (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .button_n   (button_n),
        .locked     (locked),
        .sw_rst_req (sw_rst_req),
        .rst_n_out  (rst_n_out),
        .busy       (busy),
        .rst_cause  (rst_cause)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step(1);
            n++;
        end
        check({tag, "_reach_run"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        button_n   = 1'b1;
        locked     = 1'b1;
        sw_rst_req = 1'b0;
        step(3);
        check("rst_out",   32'(rst_n_out), 32'h0);
        check("rst_busy",  32'(busy),      32'd1);
        check("rst_cause", 32'(rst_cause), 32'd0);

        // Power-on: resetn rises at cycle 0.
        resetn = 1'b1;
        step(18); check("po_c18", 32'(rst_n_out), 32'h0);
        step(1);  check("po_c19", 32'(rst_n_out), 32'h1);
        step(3);  check("po_c22", 32'(rst_n_out), 32'h1);
        step(1);  check("po_c23", 32'(rst_n_out), 32'h3);
        step(4);  check("po_c27", 32'(rst_n_out), 32'h7);
        step(3);  check("po_c30", 32'(rst_n_out), 32'h7);
        step(1);  check("po_c31", 32'(rst_n_out), 32'hf);
                  check("po_busy31", 32'(busy), 32'd1);
        step(1);  check("po_busy32", 32'(busy), 32'd0);
                  check("po_cause", 32'(rst_cause), 32'd0);

        // Software request in RUN.
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("sw_out_t1",  32'(rst_n_out), 32'h0);
        check("sw_cause",   32'(rst_cause), 32'd2);
        check("sw_busy",    32'(busy),      32'd1);
        step(16); check("sw_t17", 32'(rst_n_out), 32'h0);
        step(1);  check("sw_t18", 32'(rst_n_out), 32'h1);
        step(4);  check("sw_t22", 32'(rst_n_out), 32'h3);
        step(8);  check("sw_t30", 32'(rst_n_out), 32'hf);
                  check("sw_busy30", 32'(busy), 32'd1);
        step(1);  check("sw_busy31", 32'(busy), 32'd0);

        // Short bounce (5 cycles) must be filtered out.
        button_n = 1'b0;
        step(5);
        button_n = 1'b1;
        step(15);
        check("short_out",   32'(rst_n_out), 32'hf);
        check("short_busy",  32'(busy),      32'd0);
        check("short_cause", 32'(rst_cause), 32'd2);

        // Long press: 20 cycles.
        button_n = 1'b0;
        step(10); check("btn_p10", 32'(rst_n_out), 32'hf);
        step(1);  check("btn_p11", 32'(rst_n_out), 32'h0);
                  check("btn_cause", 32'(rst_cause), 32'd1);
        step(9);
        button_n = 1'b1;
        step(26); check("btn_r26", 32'(rst_n_out), 32'h0);
        step(1);  check("btn_r27", 32'(rst_n_out), 32'h1);
        wait_run("btn");

        // Debounced press lands in the same cycle as a software request.
        button_n = 1'b0;
        step(10);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("both_out",   32'(rst_n_out), 32'h0);
        check("both_cause", 32'(rst_cause), 32'd1);
        button_n = 1'b1;
        wait_run("both");

        // Lock loss during RELEASE, after bits 0 and 1 are released.
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(17); check("lk_t18", 32'(rst_n_out), 32'h1);
        step(4);  check("lk_t22", 32'(rst_n_out), 32'h3);
        step(1);
        locked = 1'b0;
        step(2);  check("lk_d2", 32'(rst_n_out), 32'h3);
        step(1);  check("lk_d3", 32'(rst_n_out), 32'h0);
                  check("lk_cause", 32'(rst_cause), 32'd3);
        step(30); check("lk_hold_out",  32'(rst_n_out), 32'h0);
                  check("lk_hold_busy", 32'(busy),      32'd1);
        locked = 1'b1;
        step(18); check("lk_l18", 32'(rst_n_out), 32'h0);
        step(1);  check("lk_l19", 32'(rst_n_out), 32'h1);
        wait_run("lk");
        check("lk_cause_kept", 32'(rst_cause), 32'd3);

        // Asynchronous reset in the middle of RUN.
        step(3);
        #2;
        resetn = 1'b0;
        #1;
        check("async_out",   32'(rst_n_out), 32'h0);
        check("async_busy",  32'(busy),      32'd1);
        check("async_cause", 32'(rst_cause), 32'd0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset generator/sequencer that sits directly behind the board clock and push-button reset in `chip_top`. It produces N ordered, glitch-free active-low reset outputs: for example PLL/interconnect first, then memory controller, then UART, then core. It debounces the push-button, waits for clock-lock, holds reset for a minimum time and releases the outputs one by one. After that it watches for re-trigger events and records why the last reset happened.

## Interface
- `N_OUT`, 4: number of sequenced reset outputs (≥1).
- `DEBOUNCE_CYCLES`, 1000: number of consecutive stable cycles needed before the debounced button level changes (≥1).
- `HOLD_CYCLES`, 16: minimum number of cycles in ASSERT once all release conditions are true (≥1).
- `STEP_CYCLES`, 8: number of cycles between successive output releases (≥1).
- `clock`  in  1  single clock for the whole block.
- `resetn`  in  1  asynchronous, active-low reset.
- `button_n`  in  1  raw push-button, active-low, asynchronous to `clock`.
- `locked`  in  1  clock-source lock, asynchronous to `clock`.
- `sw_rst_req`  in  1  synchronous one-cycle software reset request.
- `rst_n_out`  out  N_OUT  sequenced active-low resets, bit 0 released first.
- `busy`  out  1  high when the state is not RUN.
- `rst_cause`  out  2  cause of the last reset: 0 power-on/resetn, 1 button, 2 software, 3 lock loss.

## Operation
- Reset values while `resetn`=0: `rst_n_out`=0, `busy`=1, `rst_cause`=0, state ASSERT, all counters 0.
- `button_n` and `locked` each pass through a 2-flop synchroniser.
- Debounced button level: changes only after the synchronised button level differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles. Any match clears the debounce counter.
- `locked` is synchronised only, not debounced.
- A trigger is any of: debounced button pressed, synchronised `locked`=0, or `sw_rst_req`=1.
- ASSERT state:
  - All outputs are 0.
  - The hold counter increments while no trigger is present and clears whenever a trigger is present.
  - When the hold counter = HOLD_CYCLES−1, go to RELEASE.
- RELEASE state:
  - The step counter runs from 0.
  - `rst_n_out[k]` is set to 1 when the step counter = k·STEP_CYCLES, and stays set.
  - After bit N_OUT−1 is set, go to RUN.
- RUN state: all outputs are 1 and `busy`=0.
- A trigger in RELEASE or RUN goes to ASSERT. All outputs are 0 on the next cycle, with no partial release.
- `rst_cause` is loaded on the ASSERT entry from RELEASE or RUN. Priority when several triggers coincide: lock loss (3) > button (1) > software (2).
- Once in ASSERT, further triggers do not change `rst_cause`.
- `sw_rst_req` while already in ASSERT has no effect other than clearing the hold counter.

## Timing
- All outputs are registered.
- `resetn` falling clears every output asynchronously within the same cycle.
- `resetn` rising to `rst_n_out[0]` rising takes HOLD_CYCLES+3 cycles when `locked`=1 and the button is released: 2 synchroniser cycles, the hold time, and 1 cycle to register.
- `rst_n_out[k]` rises exactly k·STEP_CYCLES cycles after `rst_n_out[0]`.
- `busy` falls 1 cycle after `rst_n_out[N_OUT−1]` rises.
- Trigger latency, from the trigger to all outputs at 0:
  - `sw_rst_req`: 1 cycle.
  - `locked` drop: 3 cycles.
  - Button: 2+DEBOUNCE_CYCLES+1 cycles.
- Counter widths: $clog2 of max(DEBOUNCE_CYCLES, HOLD_CYCLES, (N_OUT−1)·STEP_CYCLES+1) plus 1. Counters saturate and never wrap.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum: ASSERT, RELEASE, RUN;
  - the cause codes: CAUSE_POR=0, CAUSE_BTN=1, CAUSE_SW=2, CAUSE_LOCK=3.
- Sub-module `rst_debounce`: 2-flop synchroniser plus the debounce counter, parametrised by DEBOUNCE_CYCLES. It resets to the released level (1).
- `locked` uses a bare 2-flop synchroniser inside the top.

## Test plan
Parameters for all scenarios: N_OUT=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16, STEP_CYCLES=4.
- Power-on with `locked`=1 and button released, `resetn` rising at cycle 0 → `rst_n_out` bits rise at cycles 19, 23, 27, 31; `busy` falls at 32; `rst_cause`=0.
- In RUN, `sw_rst_req` pulsed at cycle T → `rst_n_out`=4'b0000 at T+1 and `rst_cause`=2; re-release follows the same 16/4 spacing.
- In RUN, `button_n` low for 5 cycles → no change. `button_n` held low for 20 cycles → all outputs 0 at press+11 and `rst_cause`=1; outputs stay 0 until release + 2 + 8 + 16 cycles.
- In RELEASE, `locked` dropped after bits 0 and 1 are high → all outputs 0 three cycles later and `rst_cause`=3; no release occurs until `locked` is back.
- Button press and `sw_rst_req` in the same cycle in RUN → `rst_cause`=1 (button wins).
- `resetn` asserted mid-RUN → outputs 0 immediately (asynchronously), `busy`=1, `rst_cause`=0.
